// File: rtl/rsa_modexp_if.sv
// Port bundle for the modular exponentiation engine: operands and start from the
// register box, result/status back to it, plus the FSM state for observation.
interface rsa_modexp_if #(
    parameter int WIDTH = 128,
    parameter int EXP_W = 32
);
    // start is a one-cycle request honoured only while the engine is idle (no
    // queuing); done pulses for exactly one cycle, and result/error are valid in
    // that cycle. result is held until the next done; error until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;
    logic [2:0]       state_dbg;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, result, error, state_dbg
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, result, error, state_dbg
    );
endinterface

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation built on a bit-serial
// interleaved shift-add modular multiplier (one multiplier bit per clock).
module rsa_modexp #(
    parameter int WIDTH = 128,
    parameter int EXP_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    rsa_modexp_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int IW = $clog2(EXP_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQUARE = 3'd2,
        MULT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mod_q;
    logic [EXP_W-1:0] exp_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] bred_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [BW-1:0]    bit_cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic [WIDTH:0]   t_dbl;
    logic [WIDTH:0]   t_sub1;
    logic [WIDTH:0]   t_add;
    logic [WIDTH:0]   t_sub2;
    logic [WIDTH-1:0] acc_nxt;
    logic             last_bit;
    logic             exp_bit;

    // One multiplier step: acc = (2*acc + b_msb*a) mod n, kept below n by two
    // conditional subtracts; WIDTH+1 bits hold every intermediate.
    always_comb begin
        t_dbl    = {acc_q, 1'b0};
        t_sub1   = (t_dbl >= {1'b0, mod_q}) ? (t_dbl - {1'b0, mod_q}) : t_dbl;
        t_add    = t_sub1 + (b_q[WIDTH-1] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        t_sub2   = (t_add >= {1'b0, mod_q}) ? (t_add - {1'b0, mod_q}) : t_add;
        acc_nxt  = t_sub2[WIDTH-1:0];
        last_bit = (bit_cnt == '0);
        exp_bit  = exp_q[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mod_q    <= '0;
            exp_q    <= '0;
            r_q      <= '0;
            bred_q   <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mod_q   <= bus.modulus;
                        exp_q   <= bus.exponent;
                        error_q <= 1'b0;
                        idx     <= IW'(EXP_W - 1);
                        r_q     <= WIDTH'(1);
                        acc_q   <= '0;
                        bit_cnt <= BW'(WIDTH - 1);
                        if (bus.modulus[WIDTH-1:1] == '0) begin
                            state    <= FINISH;
                            error_q  <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            // Reduction is mulmod(1, base): the base shifts in as the multiplier.
                            state  <= REDUCE;
                            busy_q <= 1'b1;
                            a_q    <= WIDTH'(1);
                            b_q    <= bus.base;
                        end
                    end
                end

                REDUCE, SQUARE, MULT: begin
                    acc_q   <= acc_nxt;
                    b_q     <= b_q << 1;
                    bit_cnt <= bit_cnt - BW'(1);
                    if (last_bit) begin
                        acc_q   <= '0;
                        bit_cnt <= BW'(WIDTH - 1);
                        if (state == REDUCE) begin
                            bred_q <= acc_nxt;
                            state  <= SQUARE;
                            a_q    <= r_q;
                            b_q    <= r_q;
                        end else begin
                            r_q <= acc_nxt;
                            if (state == SQUARE && exp_bit) begin
                                state <= MULT;
                                a_q   <= acc_nxt;
                                b_q   <= bred_q;
                            end else if (idx == '0) begin
                                state    <= FINISH;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                result_q <= acc_nxt;
                            end else begin
                                idx   <= idx - IW'(1);
                                state <= SQUARE;
                                a_q   <= acc_nxt;
                                b_q   <= acc_nxt;
                            end
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.error     = error_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_rsa_modexp.sv
// Bench for rsa_modexp: directed and random operands checked against a
// right-to-left modexp model using plain wide arithmetic.
module tb_rsa_modexp;
    localparam int W = 128;
    localparam int E = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rsa_modexp_if #(.WIDTH(W), .EXP_W(E)) bus ();

    rsa_modexp #(.WIDTH(W), .EXP_W(E)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_modexp(input logic [W-1:0] b, input logic [E-1:0] e,
                                                  input logic [W-1:0] n);
        logic [2*W-1:0] r, x, nn;
        if (n < 2) return '0;
        nn = {{W{1'b0}}, n};
        r  = 1;
        x  = {{W{1'b0}}, b} % nn;
        for (int k = 0; k < E; k++) begin
            if (e[k]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[W-1:0];
    endfunction

    // Runs one operation; optionally pulses start/changes inputs at cycle disturb_at
    // and re-pulses start on the done cycle.
    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [E-1:0] e,
                          input logic [W-1:0] n, input int disturb_at, input bit poke_done);
        int cyc, busy_cnt, exp_lat;
        bit exp_err, res_chg;
        logic [W-1:0] res_before, got_exp;
        exp_err = (n < 2);
        exp_lat = exp_err ? 1 : W * (1 + E + $countones(e)) + 1;
        exp_q.push_back(model_modexp(b, e, n));
        res_before   = bus.result;
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = n;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; busy_cnt = 0; res_chg = 0;
        while (!bus.done && cyc < exp_lat + 50) begin
            if (bus.busy) busy_cnt++;
            if (bus.result !== res_before) res_chg = 1;
            bus.start = (cyc == disturb_at);
            if (cyc == disturb_at) begin
                bus.base     = ~b;
                bus.exponent = e ^ E'(1);
                bus.modulus  = n + W'(2);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        got_exp = exp_q.pop_front();
        check_eq({tag, "_done_cycle"}, cyc, exp_lat);
        check_eq({tag, "_result"}, bus.result, got_exp);
        check_eq({tag, "_error"}, bus.error, exp_err);
        check_eq({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check_eq({tag, "_busy_cycles"}, busy_cnt, exp_err ? 0 : exp_lat - 1);
        check_eq({tag, "_result_stable"}, res_chg, 1'b0);
        if (poke_done) begin
            bus.start    = 1'b1;
            bus.base     = W'($urandom);
            bus.modulus  = W'(1000);
            bus.exponent = E'(3);
            @(posedge clk); #1;
            bus.start = 1'b0;
            check_eq({tag, "_poke_busy1"}, bus.busy, 1'b0);
            @(posedge clk); #1;
            check_eq({tag, "_poke_busy2"}, bus.busy, 1'b0);
            check_eq({tag, "_poke_state"}, bus.state_dbg, 3'd0);
            check_eq({tag, "_err_held"}, bus.error, exp_err);
            check_eq({tag, "_res_held"}, bus.result, got_exp);
        end else begin
            @(posedge clk); #1;
            check_eq({tag, "_done_pulse"}, bus.done, 1'b0);
        end
    endtask

    task automatic run_reset_mid();
        int cyc;
        bit saw_done;
        bus.base = W'(4); bus.exponent = E'(13); bus.modulus = W'(497);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("rst_busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_result", bus.result, '0);
        check_eq("rst_error", bus.error, 1'b0);
        check_eq("rst_state", bus.state_dbg, 3'd0);
        saw_done = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done = 1;
        end
        check_eq("rst_no_activity", saw_done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rb, rn;
        logic [E-1:0] re;
        bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_busy", bus.busy, 1'b0);
        check_eq("reset_done", bus.done, 1'b0);
        check_eq("reset_result", bus.result, '0);
        check_eq("reset_error", bus.error, 1'b0);
        check_eq("reset_state", bus.state_dbg, 3'd0);
        @(posedge clk); #1;

        run_op("p4_13", W'(4), E'(13), W'(497), 300, 1'b1);
        run_op("enc", W'(65), E'(17), W'(3233), 0, 1'b0);
        run_op("dec", W'(2790), E'(2753), W'(3233), 0, 1'b0);
        run_op("big_base", W'(500), E'(1), W'(497), 0, 1'b0);
        run_op("exp0", W'(7), E'(0), W'(497), 0, 1'b0);
        run_op("n1", W'(12345), E'(77), W'(1), 0, 1'b1);
        run_op("clr_err", W'(4), E'(13), W'(497), 0, 1'b0);
        run_op("n0", W'(9), E'(5), W'(0), 0, 1'b0);
        run_reset_mid();
        run_op("post_rst", W'(4), E'(13), W'(497), 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rb = {$urandom, $urandom, $urandom, $urandom};
            rn = {$urandom, $urandom, $urandom, $urandom} | W'(2);
            re = E'($urandom);
            run_op($sformatf("rand%0d", k), rb, re, rn, (k == 1) ? 1000 : 0, k == 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Bit-serial modular exponentiation engine computing result = base^exponent mod modulus. It sits directly downstream of the RSA register box. That block's key-store writes drive `base`, `exponent` and `modulus`, and its "all data received" indication is turned into a one-cycle `start`. The engine's `result` is returned to the register box's output register for host read-back over the Avalon slave. Area is favoured over speed: square-and-multiply is built on an interleaved shift-add modular multiplier, one multiplier bit per cycle.

## Interface
- WIDTH, 128, width of base, modulus, result and internal accumulators
- EXP_W, 32, width of exponent
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  WIDTH  message/base operand; may be ≥ modulus
- exponent  in  EXP_W  exponent (public e or private d)
- modulus  in  WIDTH  modulus n
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when result/error valid
- result  out  WIDTH  last computed value; held until next done
- error  out  1  set with done when modulus < 2; held until next accepted start

## Operation
- States: IDLE, REDUCE, SQUARE, MULT, FINISH.
- IDLE, start=1:
  - latch base, exponent, modulus into internal registers; later input changes are ignored;
  - clear error; bit index i = EXP_W-1; r = 1.
  - If modulus < 2: go to FINISH with result=0, error=1. Otherwise go to REDUCE.
- Modular multiply primitive mulmod(a, b), with a < n:
  - acc = 0; for j = WIDTH-1 down to 0, one per cycle:
    - t = 2·acc; if t ≥ n then t −= n;
    - if b[j] then t += a; if t ≥ n then t −= n; acc = t.
  - Intermediates are WIDTH+1 bits wide.
- REDUCE: b_red = mulmod(1, base), i.e. t = 2·acc + base[j] with a single conditional subtract. Gives base mod n. Then go to SQUARE.
- SQUARE: r = mulmod(r, r).
  - If exponent[i]=1, go to MULT.
  - Otherwise, if i=0 go to FINISH, else i−−, stay in SQUARE.
- MULT: r = mulmod(r, b_red). Then if i=0 go to FINISH, else i−−, go to SQUARE.
- All EXP_W bits are processed, leading zeros included (squaring 1 yields 1). Latency therefore depends only on popcount(exponent).
- FINISH: result ← r (or 0 on error), done=1 for one cycle, back to IDLE.
- exponent=0 with modulus ≥ 2 yields result=1.
- start while busy is ignored, with no queuing.
- Reset in any state: IDLE immediately; busy=0, done=0, error=0, result=0; any in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, error=0, result=0; all internal registers 0.
- Cycle 0 is the edge that samples start in IDLE. busy=1 from cycle 1.
- Each REDUCE/SQUARE/MULT phase takes exactly WIDTH cycles. Phase transitions add no bubble cycle.
- done=1 during cycle N = WIDTH·(1 + EXP_W + popcount(exponent)) + 1; busy=0 in that same cycle. result and error are valid in that cycle.
- Error path: done in cycle 1. busy is never asserted.
- A new start is accepted in the cycle done is high's successor or later; start coincident with done is ignored (state still FINISH).
- result changes only on the done cycle.

## Test plan
- base=4, exp=13, n=497 -> done at cycle 128·36+1 = 4609, result=445, error=0; busy high cycles 1..4608.
- base=65, exp=17, n=3233 -> result=2790; then base=2790, exp=2753, n=3233 -> result=65 (encrypt/decrypt round trip).
- base=500, exp=1, n=497 -> result=3 (base ≥ modulus reduced); base=7, exp=0, n=497 -> result=1, latency 128·33+1.
- n=1, any base/exp -> done at cycle 1, result=0, error=1, busy never high; next valid start clears error.
- start pulsed again mid-operation and inputs changed after start -> ignored, original result unchanged; start on done cycle ignored.
- reset asserted at cycle 2000 of a run -> next cycle busy=0, result=0, no done pulse; fresh start then completes correctly.
